bcd_entry_ctrl: RTL
===================

# bcd_entry_ctrl

- Parametrised multi-digit BCD entry controller for the DE1 front panel.
- One push-button and four switches enter a DIGITS-wide BCD number one digit per press, least-significant digit first.
- The digit under entry is flagged for flashing, and the completed number is announced with a one-cycle valid strobe.
- It sits between the raw KEY/SW pins and the display/arithmetic logic in `top`, replacing the fixed three-digit input tracker.

## Interface
- DIGITS, 3: number of BCD digits entered (≥1).
- DEBOUNCE, 250000: consecutive stable cycles required to accept a button level (≥1).
- FLASH_DIV, 12500000: cycles per flash half-period (≥2).
- IW, $clog2(DIGITS) but at least 1: width of digit_idx (local, derived).
- CLOCK_50  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  1  data-in button, active-low, asynchronous to CLOCK_50.
- sw_digit  in  4  BCD digit to latch.
- sw_sign  in  1  sign to latch (1 = negative); used only with SIGN_EN.
- value  out  4*DIGITS  entered number; digit k occupies bits [4k+3:4k].
- sign  out  1  latched sign.
- digit_idx  out  IW  index of the digit awaiting entry.
- flash_mask  out  DIGITS  per-digit blank request for the display drivers.
- busy  out  1  high while an entry is in progress.
- valid  out  1  one-cycle strobe when an entry completes.
- err  out  1  one-cycle strobe when a digit greater than 9 is rejected.

## Operation
- key_n passes through a 2-flop synchroniser, then a debounce counter.
- The debounced level changes only after the synchronised level has differed from it for DEBOUNCE consecutive cycles; any reversion clears the counter.
- press is an internal one-cycle pulse on the debounced 1→0 transition. A held button gives exactly one press.
- State IDLE: busy=0. On press, go to ENTRY with value=0, sign=0, digit_idx=0 and the flash counter/phase cleared.
- State ENTRY: on press with sw_digit ≤ 9, write the digit into slot digit_idx.
  - If digit_idx < DIGITS-1, increment digit_idx.
  - Otherwise go to SIGN when SIGN_EN is defined, or to DONE when it is not.
- In ENTRY, a press with sw_digit > 9 pulses err, leaves value and digit_idx unchanged, and stays in ENTRY.
- State SIGN: on press, latch sign=sw_sign and go to DONE.
- State DONE: lasts exactly one cycle with valid=1. Then go to IDLE with digit_idx=0.
- value and sign hold until the next arming press in IDLE.
- Flash counter: counts 0..FLASH_DIV-1 while busy and toggles phase on wrap. It is held at 0 with phase=0 when not busy.
- flash_mask in ENTRY: one-hot(digit_idx) when phase=1, otherwise 0.
- flash_mask in SIGN: all ones when phase=1.
- flash_mask is 0 in IDLE and DONE.

## Timing
- Reset values: value=0, sign=0, digit_idx=0, flash_mask=0, busy=0, valid=0, err=0, state IDLE, debounced level=1, both counters 0.
- A clean key_n fall produces press 2+DEBOUNCE cycles later, within one cycle of synchroniser uncertainty.
- value, digit_idx, state and err update on the clock edge ending the press cycle, so they are visible one cycle after press.
- valid is high in the cycle after the final accepted press, and busy drops in the same cycle.
- A press cannot occur in the DONE cycle, because the debounce minimum spacing is ≥2 cycles.
- Asserting rst_n mid-entry immediately forces all reset values. The partial number is discarded.
- A bounce shorter than DEBOUNCE cycles produces no press.

## Configuration
- SIGN_EN defined:
  - The SIGN state exists and a fourth press (for DIGITS=3) latches sw_sign.
  - During SIGN, flash_mask blinks all digits.
- SIGN_EN undefined:
  - The SIGN state is removed and ENTRY goes directly to DONE after the last digit.
  - sign is constant 0 and sw_sign is ignored.

## Test plan
- Reset: hold rst_n=0 → all outputs 0. Release with no activity for 1000 cycles → outputs remain 0.
- Basic entry (DEBOUNCE=4, FLASH_DIV=8, SIGN_EN undefined): arm, then enter 3, 2, 1 → value=12'h123, valid for exactly one cycle, busy=0.
- Second entry 5, 7, 8 → value=12'h875.
- Invalid digit: arm, enter 4, then press with sw_digit=4'hC → err pulses once and digit_idx stays 1. Continue with 4, 0 → value=12'h044.
- Debounce: a 3-cycle low glitch on key_n → no state change. A key held low for 100 cycles → exactly one digit accepted.
- Flash: in ENTRY with digit_idx=1 → flash_mask alternates 3'b000 / 3'b010 every 8 cycles, starting at 3'b000.
- SIGN_EN defined: enter 0, 4, 4, then press with sw_sign=1 → value=12'h440, sign=1, valid pulses after the fourth digit-phase press only.
- Reset mid-entry: after two digits, assert rst_n → value=0 and busy=0. The next press arms a fresh entry at digit_idx=0.

Source files
------------

// File: rtl/bcd_entry_ctrl_if.sv
// rtl/bcd_entry_ctrl_if.sv - front-panel pins and entry results bundled between panel and bcd_entry_ctrl
interface bcd_entry_ctrl_if #(
    parameter int DIGITS = 3
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  key_n;
    logic [3:0]            sw_digit;
    logic                  sw_sign;
    logic [4*DIGITS-1:0]   value;
    logic                  sign;
    logic [IW-1:0]         digit_idx;
    logic [DIGITS-1:0]     flash_mask;
    logic                  busy;
    logic                  valid;
    logic                  err;

    modport master (
        output key_n, sw_digit, sw_sign,
        input  value, sign, digit_idx, flash_mask, busy, valid, err
    );

    modport slave (
        input  key_n, sw_digit, sw_sign,
        output value, sign, digit_idx, flash_mask, busy, valid, err
    );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// rtl/bcd_entry_ctrl.sv - multi-digit BCD entry from one button and four switches; SIGN_EN adds a sign-entry press
module bcd_entry_ctrl #(
    parameter int DIGITS    = 3,
    parameter int DEBOUNCE  = 250000,
    parameter int FLASH_DIV = 12500000
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    bcd_entry_ctrl_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int FW = $clog2(FLASH_DIV);

    typedef enum logic [1:0] {IDLE, ENTRY, SIGN, DONE} state_t;

    state_t              state;
    logic                key_s1, key_s2, key_deb, press;
    logic [CW-1:0]       deb_cnt;
    logic [FW-1:0]       flash_cnt;
    logic                phase;
    logic [4*DIGITS-1:0] value_q;
    logic [IW-1:0]       idx;
    logic                busy_q, valid_q, err_q;
    logic                sign_q;

    // press fires in the cycle the debounced level has just gone low
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_deb <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= bus.key_n;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 != key_deb) begin
                if (deb_cnt == CW'(DEBOUNCE - 1)) begin
                    key_deb <= key_s2;
                    deb_cnt <= '0;
                    press   <= key_deb;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            value_q   <= '0;
            sign_q    <= 1'b0;
            idx       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            flash_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (busy_q) begin
                if (flash_cnt == FW'(FLASH_DIV - 1)) begin
                    flash_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end else begin
                flash_cnt <= '0;
                phase     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (press) begin
                        state   <= ENTRY;
                        busy_q  <= 1'b1;
                        value_q <= '0;
                        sign_q  <= 1'b0;
                        idx     <= '0;
                    end
                end
                ENTRY: begin
                    if (press) begin
                        if (bus.sw_digit > 4'd9) begin
                            err_q <= 1'b1;
                        end else begin
                            for (int k = 0; k < DIGITS; k++)
                                if (idx == IW'(k)) value_q[4*k +: 4] <= bus.sw_digit;
                            if (idx == IW'(DIGITS - 1)) begin
`ifdef SIGN_EN
                                state <= SIGN;
`else
                                state     <= DONE;
                                busy_q    <= 1'b0;
                                valid_q   <= 1'b1;
                                flash_cnt <= '0;
                                phase     <= 1'b0;
`endif
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
`ifdef SIGN_EN
                SIGN: begin
                    if (press) begin
                        sign_q    <= bus.sw_sign;
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        valid_q   <= 1'b1;
                        flash_cnt <= '0;
                        phase     <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.flash_mask = '0;
        if (phase && state == ENTRY) begin
            for (int k = 0; k < DIGITS; k++)
                if (idx == IW'(k)) bus.flash_mask[k] = 1'b1;
        end
`ifdef SIGN_EN
        if (phase && state == SIGN) bus.flash_mask = '1;
`endif
    end

`ifdef SIGN_EN
    assign bus.sign = sign_q;
`else
    logic unused_sign;
    assign unused_sign = bus.sw_sign ^ sign_q;
    assign bus.sign    = 1'b0;
`endif

    assign bus.value     = value_q;
    assign bus.digit_idx = idx;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
endmodule
